// File: rtl/gan_seq_engine.sv
// ---------------------------------------------------------------------------
// gan_seq_engine
//
// Time-multiplexed GAN inference engine. A single shared multiply-accumulate
// unit walks the generator (N_IN -> N_G_HID -> N_PIX) and then the
// discriminator (N_PIX -> N_D_HID -> 1) one neuron at a time. Each neuron
// takes fan_in MAC cycles followed by one write-back cycle that adds the
// bias, rescales, saturates and (for hidden layers) applies ReLU.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   input vector valid            in_ready  engine can accept
//   choice     weight-set select (sampled)   choice_q  latched select
//   in_vec     generator inputs, element i at [i*WIDTH +: WIDTH]
//   wg2..wd3   weights, neuron j input i at [(j*fan_in+i)*WIDTH +: WIDTH]
//   bg2..bd3   biases, neuron j at [j*WIDTH +: WIDTH]
//   out_valid  results valid                 out_ready consumer accepts
//   pixels     generator outputs             out_disc  discriminator output
//   busy       high while a layer is being computed
//
// Optional build macro
//   ROUND_EN   when defined, write-back rounds half up instead of truncating
//              toward -inf. Saturation and latency are unaffected.
// ---------------------------------------------------------------------------
module gan_seq_engine #(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 16,
   parameter int N_IN    = 2,
   parameter int N_G_HID = 3,
   parameter int N_PIX   = 9,
   parameter int N_D_HID = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic                             choice,
   output logic                             choice_q,
   input  logic [N_IN*WIDTH-1:0]            in_vec,
   input  logic [N_IN*N_G_HID*WIDTH-1:0]    wg2,
   input  logic [N_G_HID*N_PIX*WIDTH-1:0]   wg3,
   input  logic [N_PIX*N_D_HID*WIDTH-1:0]   wd2,
   input  logic [N_D_HID*WIDTH-1:0]         wd3,
   input  logic [N_G_HID*WIDTH-1:0]         bg2,
   input  logic [N_PIX*WIDTH-1:0]           bg3,
   input  logic [N_D_HID*WIDTH-1:0]         bd2,
   input  logic [WIDTH-1:0]                 bd3,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [N_PIX*WIDTH-1:0]           pixels,
   output logic [WIDTH-1:0]                 out_disc,
   output logic                             busy
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One counter width serves both the input index (which runs up to
   // fan_in inclusive for the write-back step) and the neuron index.
   localparam int MAX_N = max2(max2(N_IN, N_G_HID), max2(N_PIX, N_D_HID));
   localparam int CW    = $clog2(MAX_N + 1);
   localparam int PW    = 2 * WIDTH;
   localparam int AW    = 2 * WIDTH + $clog2(MAX_N + 1);

   localparam logic signed [AW-1:0] SAT_HI = AW'({1'b0, {(WIDTH-1){1'b1}}});
   localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;
`ifdef ROUND_EN
   localparam logic signed [AW-1:0] ROUND_K = AW'(1) << (FRAC - 1);
`endif

   typedef enum logic [2:0] {IDLE, G_L2, G_L3, D_L2, D_L3, DONE} state_t;

   state_t                     state;
   logic [N_IN*WIDTH-1:0]      x_reg;
   logic [N_G_HID*WIDTH-1:0]   g_hid;
   logic [N_D_HID*WIDTH-1:0]   d_hid;
   logic signed [AW-1:0]       acc;
   logic [CW-1:0]              cnt_i;
   logic [CW-1:0]              cnt_j;

   logic [CW-1:0]              fan_in;
   logic [CW-1:0]              fan_out;
   logic                       relu;
   logic signed [WIDTH-1:0]    x_op;
   logic signed [WIDTH-1:0]    w_op;
   logic signed [WIDTH-1:0]    b_op;
   logic signed [PW-1:0]       prod;
   logic signed [AW-1:0]       prod_ext;
   logic signed [AW-1:0]       bias_sh;
   logic signed [AW-1:0]       sum;
   logic signed [AW-1:0]       shifted;
   logic signed [WIDTH-1:0]    wb_val;
   logic                       last_neuron;

   // Operand routing for the shared MAC: the current layer decides where the
   // activations, weights and bias come from. Operands are only fetched while
   // the input index is in range; during write-back they are unused.
   always_comb begin
      fan_in  = '0;
      fan_out = '0;
      relu    = 1'b0;
      x_op    = '0;
      w_op    = '0;
      b_op    = '0;
      case (state)
         G_L2: begin
            fan_in  = CW'(N_IN);
            fan_out = CW'(N_G_HID);
            relu    = 1'b1;
            if (cnt_i < CW'(N_IN)) begin
               x_op = x_reg[int'(cnt_i)*WIDTH +: WIDTH];
               w_op = wg2[(int'(cnt_j)*N_IN + int'(cnt_i))*WIDTH +: WIDTH];
            end
            if (cnt_j < CW'(N_G_HID)) b_op = bg2[int'(cnt_j)*WIDTH +: WIDTH];
         end
         G_L3: begin
            fan_in  = CW'(N_G_HID);
            fan_out = CW'(N_PIX);
            if (cnt_i < CW'(N_G_HID)) begin
               x_op = g_hid[int'(cnt_i)*WIDTH +: WIDTH];
               w_op = wg3[(int'(cnt_j)*N_G_HID + int'(cnt_i))*WIDTH +: WIDTH];
            end
            if (cnt_j < CW'(N_PIX)) b_op = bg3[int'(cnt_j)*WIDTH +: WIDTH];
         end
         D_L2: begin
            fan_in  = CW'(N_PIX);
            fan_out = CW'(N_D_HID);
            relu    = 1'b1;
            if (cnt_i < CW'(N_PIX)) begin
               x_op = pixels[int'(cnt_i)*WIDTH +: WIDTH];
               w_op = wd2[(int'(cnt_j)*N_PIX + int'(cnt_i))*WIDTH +: WIDTH];
            end
            if (cnt_j < CW'(N_D_HID)) b_op = bd2[int'(cnt_j)*WIDTH +: WIDTH];
         end
         D_L3: begin
            fan_in  = CW'(N_D_HID);
            fan_out = CW'(1);
            if (cnt_i < CW'(N_D_HID)) begin
               x_op = d_hid[int'(cnt_i)*WIDTH +: WIDTH];
               w_op = wd3[int'(cnt_i)*WIDTH +: WIDTH];
            end
            b_op = bd3;
         end
         default: ;
      endcase
   end

   assign prod        = PW'(x_op) * PW'(w_op);
   assign prod_ext    = AW'(prod);
   assign bias_sh     = AW'(b_op) <<< FRAC;
   assign last_neuron = (cnt_j == fan_out - 1'b1);

   // Write-back datapath: align the bias to the product scale, drop the
   // extra fractional bits with an arithmetic shift (floor), clamp to the
   // representable range, then apply ReLU for hidden layers.
   always_comb begin
      sum = acc + bias_sh;
`ifdef ROUND_EN
      sum = sum + ROUND_K;
`endif
      shifted = sum >>> FRAC;
      if (shifted > SAT_HI)
         wb_val = WIDTH'(SAT_HI);
      else if (shifted < SAT_LO)
         wb_val = WIDTH'(SAT_LO);
      else
         wb_val = WIDTH'(shifted);
      if (relu && wb_val[WIDTH-1])
         wb_val = '0;
   end

   // Sequencer: a single state machine owns the counters, the accumulator,
   // every activation register and all handshake outputs, so every output is
   // registered and reset clears the whole datapath at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         choice_q  <= 1'b0;
         x_reg     <= '0;
         g_hid     <= '0;
         d_hid     <= '0;
         pixels    <= '0;
         out_disc  <= '0;
         acc       <= '0;
         cnt_i     <= '0;
         cnt_j     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= in_vec;
                  choice_q <= choice;
                  cnt_i    <= '0;
                  cnt_j    <= '0;
                  acc      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= G_L2;
               end
            end
            G_L2, G_L3, D_L2, D_L3: begin
               if (cnt_i < fan_in) begin
                  acc   <= acc + prod_ext;
                  cnt_i <= cnt_i + 1'b1;
               end else begin
                  acc   <= '0;
                  cnt_i <= '0;
                  case (state)
                     G_L2:    g_hid[int'(cnt_j)*WIDTH +: WIDTH]  <= wb_val;
                     G_L3:    pixels[int'(cnt_j)*WIDTH +: WIDTH] <= wb_val;
                     D_L2:    d_hid[int'(cnt_j)*WIDTH +: WIDTH]  <= wb_val;
                     default: out_disc <= wb_val;
                  endcase
                  if (last_neuron) begin
                     cnt_j <= '0;
                     case (state)
                        G_L2:    state <= G_L3;
                        G_L3:    state <= D_L2;
                        D_L2:    state <= D_L3;
                        default: begin
                           state     <= DONE;
                           busy      <= 1'b0;
                           out_valid <= 1'b1;
                        end
                     endcase
                  end else begin
                     cnt_j <= cnt_j + 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gan_seq_engine.sv
// ---------------------------------------------------------------------------
// tb_gan_seq_engine
//
// Self-checking bench for gan_seq_engine at its default parameters. Expected
// pixels/discriminator values are pushed into a scoreboard queue when a
// vector is accepted and popped when the engine presents its result. Fixed
// cases use hand-derived constants; random cases use a wide-integer model.
// ---------------------------------------------------------------------------
module tb_gan_seq_engine;

   localparam int W       = 32;
   localparam int NI      = 2;
   localparam int NG      = 3;
   localparam int NP      = 9;
   localparam int ND      = 3;
   localparam int LATENCY = NG*(NI+1) + NP*(NG+1) + ND*(NP+1) + (ND+1);

   typedef logic [NP*W-1:0]    xbus_t;
   typedef logic [NP*NG*W-1:0] wbus_t;

   typedef struct {
      logic [NP*W-1:0] pix;
      logic [W-1:0]    disc;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              inValid;
   logic              inReady;
   logic              choice;
   logic              choiceQ;
   logic [NI*W-1:0]   inVec;
   logic [NI*NG*W-1:0] wg2;
   logic [NG*NP*W-1:0] wg3;
   logic [NP*ND*W-1:0] wd2;
   logic [ND*W-1:0]   wd3;
   logic [NG*W-1:0]   bg2;
   logic [NP*W-1:0]   bg3;
   logic [ND*W-1:0]   bd2;
   logic [W-1:0]      bd3;
   logic              outValid;
   logic              outReady;
   logic [NP*W-1:0]   pixels;
   logic [W-1:0]      outDisc;
   logic              busy;

   exp_t sbQ[$];
   int   checks;
   int   errors;
   int   cycleCnt;
   int   acceptCyc;
   logic lastChoice;

   gan_seq_engine dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .choice    (choice),
      .choice_q  (choiceQ),
      .in_vec    (inVec),
      .wg2       (wg2),
      .wg3       (wg3),
      .wd2       (wd2),
      .wd3       (wd3),
      .bg2       (bg2),
      .bg3       (bg3),
      .bd2       (bd2),
      .bd3       (bd3),
      .out_valid (outValid),
      .out_ready (outReady),
      .pixels    (pixels),
      .out_disc  (outDisc),
      .busy      (busy)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference neuron using 128-bit integer arithmetic: bias scaled by
   // 2^16, exact products, floor division by 2^16, clamp, optional ReLU.
   function automatic logic signed [W-1:0] refNeuron(input xbus_t xs, input int fanIn,
                                                     input wbus_t ws, input int j,
                                                     input logic signed [W-1:0] b, input bit relu);
      logic signed [127:0] a;
      logic signed [127:0] r;
      logic signed [W-1:0] res;
      a = 128'(b) * 128'sd65536;
      for (int i = 0; i < fanIn; i++)
         a = a + 128'($signed(xs[i*W +: W])) * 128'($signed(ws[(j*fanIn+i)*W +: W]));
`ifdef ROUND_EN
      a = a + 128'sd32768;
`endif
      r = a >>> 16;
      if (r > 128'sd2147483647)
         res = 32'h7FFF_FFFF;
      else if (r < -128'sd2147483648)
         res = 32'h8000_0000;
      else
         res = W'(r);
      if (relu && res < 0)
         res = '0;
      return res;
   endfunction

   function automatic exp_t refModel(input logic [NI*W-1:0] v);
      exp_t  e;
      xbus_t hg;
      xbus_t hd;
      hg = '0;
      hd = '0;
      for (int j = 0; j < NG; j++)
         hg[j*W +: W] = refNeuron(xbus_t'(v), NI, wbus_t'(wg2), j, bg2[j*W +: W], 1'b1);
      for (int j = 0; j < NP; j++)
         e.pix[j*W +: W] = refNeuron(hg, NG, wbus_t'(wg3), j, bg3[j*W +: W], 1'b0);
      for (int j = 0; j < ND; j++)
         hd[j*W +: W] = refNeuron(xbus_t'(e.pix), NP, wbus_t'(wd2), j, bd2[j*W +: W], 1'b1);
      e.disc = refNeuron(hd, ND, wbus_t'(wd3), 0, bd3, 1'b0);
      return e;
   endfunction

   function automatic exp_t mkExp(input logic [W-1:0] p, input logic [W-1:0] d);
      exp_t e;
      for (int i = 0; i < NP; i++) e.pix[i*W +: W] = p;
      e.disc = d;
      return e;
   endfunction

   task automatic setUniform(input logic [W-1:0] wv, input logic [W-1:0] bv);
      for (int i = 0; i < NI*NG; i++) wg2[i*W +: W] = wv;
      for (int i = 0; i < NG*NP; i++) wg3[i*W +: W] = wv;
      for (int i = 0; i < NP*ND; i++) wd2[i*W +: W] = wv;
      for (int i = 0; i < ND; i++)    wd3[i*W +: W] = wv;
      for (int i = 0; i < NG; i++)    bg2[i*W +: W] = bv;
      for (int i = 0; i < NP; i++)    bg3[i*W +: W] = bv;
      for (int i = 0; i < ND; i++)    bd2[i*W +: W] = bv;
      bd3 = bv;
   endtask

   // Weights in [-1.0, 1.0], biases in [-2.0, 2.0], with fractional bits.
   task automatic setRandom();
      for (int i = 0; i < NI*NG; i++) wg2[i*W +: W] = $urandom_range(0, 131072) - 65536;
      for (int i = 0; i < NG*NP; i++) wg3[i*W +: W] = $urandom_range(0, 131072) - 65536;
      for (int i = 0; i < NP*ND; i++) wd2[i*W +: W] = $urandom_range(0, 131072) - 65536;
      for (int i = 0; i < ND; i++)    wd3[i*W +: W] = $urandom_range(0, 131072) - 65536;
      for (int i = 0; i < NG; i++)    bg2[i*W +: W] = $urandom_range(0, 262144) - 131072;
      for (int i = 0; i < NP; i++)    bg3[i*W +: W] = $urandom_range(0, 262144) - 131072;
      for (int i = 0; i < ND; i++)    bd2[i*W +: W] = $urandom_range(0, 262144) - 131072;
      bd3 = $urandom_range(0, 262144) - 131072;
   endtask

   function automatic logic [NI*W-1:0] randVec();
      logic [NI*W-1:0] v;
      for (int i = 0; i < NI; i++) v[i*W +: W] = $urandom_range(0, 524288) - 262144;
      return v;
   endfunction

   // Called at a falling edge with the engine idle. Offers one vector,
   // records the accept cycle and queues the expected result.
   task automatic applyStimulus(input logic [NI*W-1:0] v, input logic ch, input exp_t e);
      checkOutput("in_ready_idle", 64'(inReady), 64'd1);
      inVec   = v;
      choice  = ch;
      inValid = 1'b1;
      sbQ.push_back(e);
      lastChoice = ch;
      @(posedge clk);
      #1;
      acceptCyc = cycleCnt;
      checkOutput("busy_run", 64'(busy), 64'd1);
      checkOutput("in_ready_run", 64'(inReady), 64'd0);
      checkOutput("choice_q", 64'(choiceQ), 64'(ch));
      @(negedge clk);
      inValid = 1'b0;
      choice  = ~ch;
      inVec   = randVec();
   endtask

   // Waits (bounded) for a result, compares it against the scoreboard,
   // optionally holds backpressure while pulsing in_valid, then completes
   // the output handshake. Ends on a falling edge with the engine idle.
   task automatic collectResult(input int holdCycles);
      exp_t e;
      for (int k = 0; k < 300 && !outValid; k++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("out_valid_seen", 64'(outValid), 64'd1);
      checkOutput("latency", 64'(cycleCnt - acceptCyc), 64'(LATENCY));
      @(negedge clk);
      if (sbQ.size() == 0) begin
         checkOutput("sb_nonempty", 64'd0, 64'd1);
         e = mkExp('0, '0);
      end else begin
         e = sbQ.pop_front();
      end
      for (int i = 0; i < NP; i++)
         checkOutput($sformatf("pix%0d", i), 64'(pixels[i*W +: W]), 64'(e.pix[i*W +: W]));
      checkOutput("disc", 64'(outDisc), 64'(e.disc));
      checkOutput("busy_done", 64'(busy), 64'd0);
      checkOutput("in_ready_done", 64'(inReady), 64'd0);
      checkOutput("choice_q_held", 64'(choiceQ), 64'(lastChoice));
      for (int k = 0; k < holdCycles; k++) begin
         inValid = ~inValid;
         inVec   = randVec();
         choice  = ~choice;
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", 64'(outValid), 64'd1);
         checkOutput("bp_in_ready", 64'(inReady), 64'd0);
         checkOutput("bp_busy", 64'(busy), 64'd0);
         checkOutput("bp_pix_stable", 64'(pixels == e.pix), 64'd1);
         checkOutput("bp_disc_stable", 64'(outDisc), 64'(e.disc));
         checkOutput("bp_choice_q", 64'(choiceQ), 64'(lastChoice));
         @(negedge clk);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("out_valid_clear", 64'(outValid), 64'd0);
      checkOutput("in_ready_back", 64'(inReady), 64'd1);
      @(negedge clk);
      outReady = 1'b0;
   endtask

   initial begin
      logic [NI*W-1:0] v;
      exp_t            e;
      checks   = 0;
      errors   = 0;
      rst      = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b0;
      choice   = 1'b0;
      inVec    = '0;
      setUniform('0, '0);

      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_choice_q", 64'(choiceQ), 64'd0);
      checkOutput("rst_pixels_zero", 64'(pixels == '0), 64'd1);
      checkOutput("rst_disc", 64'(outDisc), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] zero weights, unit biases");
      setUniform('0, 32'h0001_0000);
      applyStimulus(randVec(), 1'b1, mkExp(32'h0001_0000, 32'h0001_0000));
      collectResult(0);

      $display("[TB] unit weights, inputs 1.0 and 2.0");
      setUniform(32'h0001_0000, '0);
      v = {32'h0002_0000, 32'h0001_0000};
      applyStimulus(v, 1'b0, mkExp(32'h0009_0000, 32'h00F3_0000));
      collectResult(0);

      $display("[TB] ReLU on generator hidden layer");
      v = {32'h0000_0000, 32'hFFFF_0000};
      applyStimulus(v, 1'b1, mkExp('0, '0));
      collectResult(0);

      $display("[TB] positive saturation");
      v = {32'h7FFF_0000, 32'h7FFF_0000};
      applyStimulus(v, 1'b0, mkExp(32'h7FFF_FFFF, 32'h7FFF_FFFF));
      collectResult(0);

      $display("[TB] negated weights clamp through ReLU");
      setUniform(32'hFFFF_0000, '0);
      applyStimulus(v, 1'b1, mkExp('0, '0));
      collectResult(0);

      $display("[TB] random weights and inputs");
      for (int n = 0; n < 3; n++) begin
         setRandom();
         v = randVec();
         applyStimulus(v, n[0], refModel(v));
         collectResult(0);
      end

      $display("[TB] backpressure with in_valid pulsing");
      setUniform(32'h0001_0000, '0);
      v = {32'h0002_0000, 32'h0001_0000};
      applyStimulus(v, 1'b1, mkExp(32'h0009_0000, 32'h00F3_0000));
      collectResult(10);
      setRandom();
      v = randVec();
      applyStimulus(v, 1'b0, refModel(v));
      collectResult(0);

      $display("[TB] reset in the middle of an inference");
      v = randVec();
      applyStimulus(v, 1'b1, refModel(v));
      for (int k = 0; k < 100 && (cycleCnt - acceptCyc) < 40; k++)
         @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("mid_rst_busy", 64'(busy), 64'd0);
      checkOutput("mid_rst_in_ready", 64'(inReady), 64'd1);
      checkOutput("mid_rst_pixels_zero", 64'(pixels == '0), 64'd1);
      checkOutput("mid_rst_disc", 64'(outDisc), 64'd0);
      checkOutput("mid_rst_choice_q", 64'(choiceQ), 64'd0);
      sbQ.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      e = refModel(v);
      applyStimulus(v, 1'b0, e);
      collectResult(0);

      checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gan_seq_engine.md
Name: gan_seq_engine

Overview:
Parametrised, time-multiplexed successor to the fully-parallel GAN inference top level. One shared MAC evaluates the generator (N_IN -> N_G_HID -> N_PIX) and then the discriminator (N_PIX -> N_D_HID -> 1) neuron by neuron. A valid/ready handshake sits on both input and output. Weights and biases arrive as flattened buses from the weight and bias memories. The selected weight set is latched per inference.

Parameters:
WIDTH, 32, data width, signed fixed point Q(WIDTH-FRAC).FRAC
FRAC, 16, fractional bits
N_IN, 2, generator input count
N_G_HID, 3, generator hidden neurons
N_PIX, 9, generator output pixels (discriminator inputs)
N_D_HID, 3, discriminator hidden neurons

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  input vector valid
in_ready  out  1  engine can accept
choice  in  1  weight-set select, sampled on accept
choice_q  out  1  latched select, drives weight/bias memories
in_vec  in  N_IN*WIDTH  generator inputs, element i at [i*WIDTH +: WIDTH]
wg2, wg3, wd2, wd3  in  fan_in*fan_out*WIDTH each  weights, neuron j input i at [(j*fan_in+i)*WIDTH +: WIDTH]
bg2, bg3, bd2, bd3  in  fan_out*WIDTH each  biases, neuron j at [j*WIDTH +: WIDTH]
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
pixels  out  N_PIX*WIDTH  generator outputs
out_disc  out  WIDTH  discriminator output
busy  out  1  high in any compute state

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0): state IDLE. in_ready=1. out_valid=0, busy=0, choice_q=0. pixels, out_disc and all internal activations = 0.
- FSM states: IDLE, G_L2, G_L3, D_L2, D_L3, DONE.
- IDLE: in_ready=1. Accept occurs on an edge with in_valid=1. On accept: latch in_vec and choice into choice_q, clear the neuron and input counters, go to G_L2.
- Per neuron in each layer:
  - fan_in MAC cycles: acc += x[i]*w[j][i]. Products are full 2*WIDTH signed. The accumulator has 2*WIDTH+clog2(fan_in+1) bits.
  - Then 1 write-back cycle: sum = acc + (b[j] <<< FRAC); r = sum >>> FRAC (arithmetic, truncate toward -inf); saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; store; clear acc.
- Activation: ReLU (negative -> 0) on G_L2 and D_L2 outputs. G_L3 and D_L3 are linear.
- Layer transitions: after the last neuron's write-back, G_L2->G_L3->D_L2->D_L3->DONE.
- Inputs per layer: G_L2 uses latched in_vec. G_L3 uses G_L2 results. D_L2 uses the pixel registers. D_L3 uses D_L2 results.
- pixels updates at each G_L3 write-back. out_disc updates at the D_L3 write-back.
- Latency: accept edge to out_valid=1 is N_G_HID*(N_IN+1) + N_PIX*(N_G_HID+1) + N_D_HID*(N_PIX+1) + (N_D_HID+1) cycles. This is 79 at the defaults.
- DONE: out_valid=1. pixels and out_disc are held stable and in_ready=0 while out_ready=0. On an edge with out_ready=1: out_valid=0, go to IDLE. The next accept is possible one cycle later.
- in_valid is ignored outside IDLE.
- Weight and bias buses must be stable from accept until DONE. choice changes outside IDLE have no effect.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The partial result is discarded.
- busy=1 in G_L2..D_L3, 0 in IDLE and DONE.

Optional Feature:
ROUND_EN
- Defined: at write-back, add 2^(FRAC-1) to sum before the shift (round half up). Saturation is unchanged. Latency is unchanged.
- Undefined: pure truncation as above.

Test Plan:
- Zero weights, all biases 1.0 (0x00010000), any inputs -> all 9 pixels = 0x00010000, out_disc = 0x00010000, out_valid exactly 79 cycles after accept.
- All weights 1.0, biases 0, in_vec = {1.0, 2.0} -> pixels = 9.0 (0x00090000), out_disc = 243.0 (0x00F30000).
- ReLU check: weights 1.0, biases 0, in_vec = {-1.0, 0} -> G hidden = 0, pixels = 0, out_disc = 0.
- Saturation: weights 1.0, in_vec = {0x7FFF0000, 0x7FFF0000} -> G hidden = 0x7FFFFFFF, pixels and out_disc = 0x7FFFFFFF. With negated weights, all values clamp to 0 after ReLU.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE, and a second vector is accepted on the next cycle.
- Reset mid-run: drive rst=0 at cycle 40 after accept -> out_valid=0, busy=0, pixels=0, in_ready=1. After release, a fresh inference completes correctly in 79 cycles.
